countdown_ctrl: RTL
===================

// Module: countdown_ctrl
// PURPOSE
//  Run controller for the two-digit 99..00 seven-segment countdown on the Nexys 4 DDR.
//  Replaces the toggled divided clock with a 1-cycle tick enable from an internal prescaler.
//  Everything stays in the single clk domain.
//  Sequences load/start/pause/terminal count and drives BCD digits to the segment mux.
// PARAMETERS
//  TICK_DIV   100_000_000  clk cycles per count step; sim benches override to 4; legal >= 2
//  DEF_LOAD   99           start value after reset; legal 0..99
// PORTS
//  clk        in   1  100 MHz board clock
//  reset      in   1  async, active-high; clears all state
//  load       in   1  1-cycle strobe: capture load_val
//  load_val   in   7  binary 0..99; values >99 clamp to 99
//  start      in   1  1-cycle strobe: run/resume/restart
//  pause      in   1  1-cycle strobe: freeze count and prescaler
//  tick       out  1  1-cycle pulse per count step, only while RUN
//  tens       out  4  BCD tens digit
//  ones       out  4  BCD ones digit
//  running    out  1  high in RUN
//  done       out  1  high in DONE (count reached 00)
// BEHAVIOUR
//  Reset: state=IDLE, reload=DEF_LOAD, tens/ones=DEF_LOAD in BCD, prescaler=0.
//  Reset: tick=0, running=0, done=0. All outputs are registered.
//  States: IDLE, RUN, PAUSE, DONE.
//  Priority each cycle: load > start > pause. Only one is acted on.
//  load (any state): reload<=clamp(load_val); digits<=BCD(reload value) next cycle.
//  load (any state): state->IDLE, prescaler cleared.
//  IDLE  start -> RUN, prescaler cleared. pause ignored.
//  RUN   prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and tick=1 next cycle.
//  RUN   on the same cycle as tick, digits decrement by one BCD step.
//  RUN   ones 0 -> 9 with tens-1. ones!=0 -> ones-1.
//  RUN   step taken from 01 -> digits 00, state->DONE, running=0, done=1, no further ticks.
//  RUN   start at 00 -> DONE immediately, no tick.
//  RUN   pause -> PAUSE; prescaler value held, so resume keeps phase.
//  RUN   start is ignored.
//  PAUSE start -> RUN, prescaler continues from held value. pause ignored.
//  DONE  digits hold 00, done=1.
//  DONE  start -> digits<=BCD(reload), prescaler cleared, RUN (restart). pause ignored.
//  First tick after start or restart: exactly TICK_DIV cycles after the start strobe.
//  reset mid-RUN: all state returns to reset values asynchronously; no partial tick.
//  digits are never outside 0..9; tens never outside 0..9.
// STRUCTURE
//  Shared pkg (countdown_pkg): state encodings (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3).
//  Shared pkg (countdown_pkg): MAX_COUNT=99 and the BCD digit width of 4.
//  Sub-module tick_prescaler: inputs clk, reset, en, clr; output tick.
//  tick_prescaler: $clog2(TICK_DIV)-bit counter.
//  tick_prescaler: en low holds the counter; clr zeroes it with priority over en.
//  Top holds the FSM, the reload register, binary->BCD conversion on load (/10 via compare chain) and the BCD decrementer.
// TESTING  (TICK_DIV=4, DEF_LOAD=99)
//  1. Release reset, idle 20 cycles.
//     -> tens/ones=9/9, tick never high, running=0, done=0.
//  2. load_val=12 + load, then start.
//     -> tick every 4 cycles, first tick 4 cycles after start.
//     -> digits 12,11,10,09,...,01,00; done=1 after the 12th tick; no 13th tick.
//  3. load_val=20, start, pause after 2 cycles, wait 10, start.
//     -> first tick exactly 2 cycles after resume, digits 20 -> 19 with correct borrow.
//  4. load_val=120 + load.
//     -> digits 99.
//     load_val=0 + load, then start.
//     -> DONE next cycle, zero ticks.
//  5. load and start asserted same cycle in RUN.
//     -> load wins, state IDLE, digits = new value.
//  6. Assert reset in RUN at digits 37.
//     -> outputs at reset values immediately.
//     Start after release.
//     -> countdown from 99.
//  7. In DONE, start.
//     -> digits reload last loaded value, running=1, first tick after 4 cycles.

Source files
------------

// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encodings, count limits and BCD helpers
package countdown_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
  localparam int MAX_COUNT = 99;
  localparam int DIGIT_W = 4;
  function automatic logic [6:0] clamp(input logic [6:0] v);
    return (v > 7'(MAX_COUNT)) ? 7'(MAX_COUNT) : v;
  endfunction
  function automatic logic [2*DIGIT_W-1:0] to_bcd(input logic [6:0] v);
    logic [3:0] t;
    t = '0;
    for (int i = 1; i < 10; i++) if (v >= 7'(i * 10)) t = 4'(i);
    return {t, 4'(v - 7'(t) * 7'd10)};
  endfunction
endpackage

// File: rtl/countdown_tick_prescaler.sv
// tick_prescaler: free-running step divider with hold and clear
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = en && !clr && (cnt_q == W'(TICK_DIV - 1));
  // clear beats enable; wrap to zero on the terminal count
  always_comb cnt_d = clr ? '0 : tick ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: load/start/pause sequencer for a two-digit BCD countdown
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int DEF_LOAD = 99
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [6:0]         load_val,
  input  logic               start,
  input  logic               pause,
  output logic               tick,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               running,
  output logic               done
);
  state_t state_q, state_d;
  logic [6:0] reload_q, reload_d;
  logic [2*DIGIT_W-1:0] digits_q, digits_d, dec;
  logic tick_q, en, clr, wrap;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .tick(wrap)
  );
  assign dec = (digits_q[3:0] == 4'd0) ? {digits_q[7:4] - 4'd1, 4'd9} : {digits_q[7:4], digits_q[3:0] - 4'd1};
  // next state, digits and prescaler control; load outranks start outranks pause
  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    digits_d = digits_q;
    en       = 1'b0;
    clr      = 1'b0;
    if (load) begin
      reload_d = clamp(load_val);
      digits_d = to_bcd(clamp(load_val));
      state_d  = IDLE;
      clr      = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          clr     = 1'b1;
          state_d = (digits_q == '0) ? DONE : RUN;
        end
        RUN: if (digits_q == '0) state_d = DONE;
        else if (pause) state_d = PAUSE;
        else begin
          en = 1'b1;
          if (wrap) begin
            digits_d = dec;
            state_d  = (digits_q == 8'h01) ? DONE : RUN;
          end
        end
        PAUSE: if (start) state_d = RUN;
        DONE: if (start) begin
          clr      = 1'b1;
          digits_d = to_bcd(reload_q);
          state_d  = (reload_q == '0) ? DONE : RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state, reload value, digits and tick pulse registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      reload_q <= 7'(DEF_LOAD);
      digits_q <= to_bcd(7'(DEF_LOAD));
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      digits_q <= digits_d;
      tick_q   <= wrap;
    end
  assign tick    = tick_q;
  assign tens    = digits_q[7:4];
  assign ones    = digits_q[3:0];
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);
endmodule
